serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial adder sequencer: adds two WIDTH-bit operands plus carry-in by
//   stepping a single 1-bit full-adder slice once per clock, LSB first.
//   Trades WIDTH cycles of latency for one FA cell. Owns operand shift
//   registers, carry flop, bit counter and start/busy/done handshake.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (legal: WIDTH >= 1)
// PORTS
//   clk    input   1      rising-edge clock
//   rst_n  input   1      asynchronous active-low reset
//   start  input   1      request; sampled only in IDLE
//   a      input   WIDTH  operand A, captured on accepted start
//   b      input   WIDTH  operand B, captured on accepted start
//   cin    input   1      carry-in, captured on accepted start
//   busy   output  1      high while in RUN
//   done   output  1      one-cycle completion pulse (high in DONE)
//   sum    output  WIDTH  result; holds last completed value
//   cout   output  1      carry-out of MSB; holds last completed value
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; busy=0, done=0, sum=0, cout=0;
//     internal shift regs, carry flop, counter cleared.
//   FSM states: IDLE, RUN, DONE. All outputs registered / Moore-decoded.
//   IDLE: start=1 at edge -> load a_sh<=a, b_sh<=b, c<=cin, cnt<=0, go RUN.
//     start=0 -> stay. busy=0, done=0.
//   RUN (busy=1): each edge processes bit a_sh[0], b_sh[0] with carry c:
//     s = a_sh[0]^b_sh[0]^c;  c <= (a_sh[0]^b_sh[0])&c | a_sh[0]&b_sh[0];
//     s_sh <= {s, s_sh[WIDTH-1:1]}; a_sh, b_sh shift right 1; cnt <= cnt+1.
//     On the edge processing bit WIDTH-1 (cnt==WIDTH-1): sum <= final
//     {s, s_sh[WIDTH-1:1]}, cout <= carry of that bit, go DONE.
//   DONE: done=1 for exactly one cycle; unconditionally -> IDLE next edge.
//   Latency: start accepted at edge 0 -> done high in the cycle after edge
//     WIDTH (WIDTH+1 edges). Next start accepted earliest at the edge
//     leaving DONE+1 (i.e. once back in IDLE); throughput 1 op / WIDTH+2 cyc.
//   start in RUN or DONE: ignored, no queuing; operands not re-sampled.
//   a/b/cin changes after acceptance: no effect on in-flight operation.
//   sum/cout: unchanged during RUN; update only at final RUN edge; hold
//     through IDLE until next completion.
//   Reset mid-RUN: operation aborted, all outputs to reset values; no done.
//   Arithmetic: {cout,sum} == a + b + cin exactly, modulo 2^(WIDTH+1).
//   cnt width: $clog2(WIDTH+1) bits; WIDTH=1 completes in one RUN cycle.
// TESTING
//   1. WIDTH=8, a=8'h5A,b=8'h3C,cin=0, start 1 cyc -> busy 8 cyc, done
//      pulse 1 cyc after edge 8, sum=8'h96, cout=0.
//   2. a=8'hFF,b=8'h01,cin=0 -> sum=8'h00,cout=1; a=8'hFF,b=8'hFF,cin=1 ->
//      sum=8'hFF,cout=1 (full ripple of carry).
//   3. start held high and a/b toggled during RUN -> single done pulse,
//      result of operands at acceptance only; start in DONE not accepted.
//   4. rst_n low at RUN cycle 4 of a=8'h12,b=8'h34 -> busy/done/sum/cout=0
//      immediately (async); after release, new op 8'h01+8'h01 -> sum=8'h02.
//   5. WIDTH=4 exhaustive a,b in 0..15, cin in {0,1} (512 ops, back-to-back
//      start asserted at first IDLE cycle) -> {cout,sum}==a+b+cin each op.
//   6. WIDTH=1: a=1,b=1,cin=1 -> done 2 edges after start, sum=1, cout=1;
//      sum/cout stable across 20 idle cycles afterwards.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first,
// using a single full-adder slice behind a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, s_sh_q, s_sh_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d;
  logic s, carry, last;
  logic [WIDTH:0] s_ext;
  always_comb begin
    s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    carry = ((a_sh_q[0] ^ b_sh_q[0]) & c_q) | (a_sh_q[0] & b_sh_q[0]);
    // shifting the widened vector keeps {s, s_sh[WIDTH-1:1]} legal when WIDTH is 1
    s_ext = {s, s_sh_q} >> 1;
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    s_sh_d = s_sh_q;
    c_d = c_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    cout_d = cout_q;
    unique case (state_q)
      IDLE: if (start) begin
        a_sh_d = a;
        b_sh_d = b;
        c_d = cin;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = s_ext[WIDTH-1:0];
        c_d = carry;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          sum_d = s_ext[WIDTH-1:0];
          cout_d = carry;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q <= '0;
      b_sh_q <= '0;
      s_sh_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      s_sh_q <= s_sh_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: drives WIDTH=8/4/1 instances and checks every cycle against a
// cycle-count model that predicts busy/done timing and {cout,sum} = a + b + cin.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st[3];
  logic [7:0] av[3], bv[3];
  logic ci[3];
  logic bz[3], dn[3], co[3];
  logic [7:0] sm8;
  logic [3:0] sm4;
  logic sm1;
  int ph[3];
  logic [8:0] pend[3], res[3];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]),
    .cin(ci[0]), .busy(bz[0]), .done(dn[0]), .sum(sm8), .cout(co[0]));
  serial_adder_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][3:0]), .b(bv[1][3:0]),
    .cin(ci[1]), .busy(bz[1]), .done(dn[1]), .sum(sm4), .cout(co[1]));
  serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2][0]), .b(bv[2][0]),
    .cin(ci[2]), .busy(bz[2]), .done(dn[2]), .sum(sm1), .cout(co[2]));

  function automatic int wof(int g);
    return g == 0 ? 8 : (g == 1 ? 4 : 1);
  endfunction

  function automatic logic [8:0] msk(int g);
    return 9'((9'd1 << wof(g)) - 9'd1);
  endfunction

  function automatic int actual(int g);
    return g == 0 ? int'({co[0], sm8}) : (g == 1 ? int'({co[1], sm4}) : int'({co[2], sm1}));
  endfunction

  // ph: 0 idle, 1..W busy cycles, W+1 the done cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 3; g++) begin
        ph[g] <= 0;
        pend[g] <= '0;
        res[g] <= '0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (ph[g] == 0) begin
          if (st[g]) begin
            ph[g] <= 1;
            pend[g] <= ({1'b0, av[g]} & msk(g)) + ({1'b0, bv[g]} & msk(g)) + {8'd0, ci[g]};
          end
        end else if (ph[g] <= wof(g)) begin
          ph[g] <= ph[g] + 1;
          if (ph[g] == wof(g)) res[g] <= pend[g];
        end else ph[g] <= 0;
      end
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("busy[w%0d]", wof(g)), int'(bz[g]), int'(ph[g] >= 1 && ph[g] <= wof(g)));
      chk($sformatf("done[w%0d]", wof(g)), int'(dn[g]), int'(ph[g] == wof(g) + 1));
      chk($sformatf("result[w%0d]", wof(g)), actual(g), int'(res[g]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic op(input int g, input logic [7:0] a, input logic [7:0] b, input logic c,
                    output int edges, output int busy_n);
    st[g] = 1'b1;
    av[g] = a;
    bv[g] = b;
    ci[g] = c;
    tick();
    st[g] = 1'b0;
    av[g] = 8'($urandom);
    bv[g] = 8'($urandom);
    ci[g] = 1'($urandom);
    edges = 1;
    busy_n = int'(bz[g]);
    while (!dn[g] && edges < 40) begin
      tick();
      edges++;
      busy_n += int'(bz[g]);
    end
    if (edges >= 40) chk("done_timeout", 0, 1);
    tick();
  endtask

  int e, bc, k, dcount;
  logic [8:0] ii;

  initial begin
    for (int g = 0; g < 3; g++) begin
      st[g] = 1'b0;
      av[g] = '0;
      bv[g] = '0;
      ci[g] = 1'b0;
    end
    #1 check_all();
    chk("reset_sum8", actual(0), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    // basic add: 0x5A + 0x3C = 0x96
    op(0, 8'h5A, 8'h3C, 1'b0, e, bc);
    chk("t1_result", actual(0), 'h096);
    chk("t1_model", int'(res[0]), 'h096);
    chk("t1_edges", e, 9);
    chk("t1_busy_cycles", bc, 8);
    op(0, 8'hFF, 8'h01, 1'b0, e, bc);
    chk("t2_ff_01", actual(0), 'h100);
    op(0, 8'hFF, 8'hFF, 1'b1, e, bc);
    chk("t2_ff_ff_1", actual(0), 'h1FF);
    // start held through RUN and DONE with operands toggling
    st[0] = 1'b1;
    av[0] = 8'h11;
    bv[0] = 8'h22;
    ci[0] = 1'b0;
    tick();
    dcount = 0;
    for (int i = 0; i < 9; i++) begin
      av[0] = 8'($urandom);
      bv[0] = 8'($urandom);
      tick();
      dcount += int'(dn[0]);
    end
    st[0] = 1'b0;
    repeat (3) tick();
    chk("t3_done_pulses", dcount, 1);
    chk("t3_result", actual(0), 'h033);
    chk("t3_idle", int'(bz[0]), 0);
    // asynchronous reset in RUN cycle 4
    st[0] = 1'b1;
    av[0] = 8'h12;
    bv[0] = 8'h34;
    tick();
    st[0] = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 check_all();
    chk("t4_busy_reset", int'(bz[0]), 0);
    chk("t4_result_reset", actual(0), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    op(0, 8'h01, 8'h01, 1'b0, e, bc);
    chk("t4_after_reset", actual(0), 'h002);
    // WIDTH=1 corner
    op(2, 8'h01, 8'h01, 1'b1, e, bc);
    chk("t6_edges", e, 2);
    chk("t6_result", actual(2), 'h3);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_hold", actual(2), 'h3);
    end
    // WIDTH=4 exhaustive, start held so each op is accepted at the first IDLE edge
    st[1] = 1'b1;
    for (int i = 0; i < 512; i++) begin
      ii = 9'(i);
      av[1] = {4'd0, ii[3:0]};
      bv[1] = {4'd0, ii[7:4]};
      ci[1] = ii[8];
      k = 0;
      do begin
        tick();
        k++;
      end while (ph[1] != 1 && k < 20);
      if (k >= 20) chk("t5_accept_timeout", 0, 1);
    end
    st[1] = 1'b0;
    repeat (6) tick();
    chk("t5_last", actual(1), 31);
    // random operations on all widths
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(2, 0));
      op(k, 8'($urandom), 8'($urandom), 1'($urandom), e, bc);
      chk("rand_edges", e, wof(k) + 1);
      chk("rand_busy_cycles", bc, wof(k));
      repeat ($urandom_range(2, 0)) tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
